// File: rtl/note_pkg.sv
// note_pkg: shared note types and constants for the falling-note engine
package note_pkg;
  localparam int MAX_STREAK = 255;
  localparam int MAX_LANES = 8;
  typedef logic [9:0] note_y_t;
  typedef logic [$clog2(MAX_LANES)-1:0] lane_idx_t;
  typedef struct packed {
    logic    active;
    note_y_t y;
  } note_slot_t;
endpackage

// File: rtl/note_lane.sv
// note_lane: one lane's slot array with tick move, miss detect, spawn insert, press judge and pixel test
module note_lane
  import note_pkg::*;
#(
  parameter int NOTES     = 4,
  parameter int SPEED     = 2,
  parameter int HIT_Y     = 420,
  parameter int HIT_WIN   = 12,
  parameter int X0        = 160,
  parameter int NOTE_SIZE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       spawn,
  input  logic       press,
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  output logic       ready,
  output logic       hit,
  output logic       miss,
  output logic       pix
);
  localparam int IW = $clog2(NOTES);
  localparam logic [10:0] WIN_LO = 11'(HIT_Y - HIT_WIN);
  localparam logic [10:0] WIN_HI = 11'(HIT_Y + HIT_WIN);
  note_slot_t [NOTES-1:0] slot_q, slot_d;
  logic [IW-1:0] best, free_idx;
  note_y_t best_y;
  logic found, xin;
  logic [10:0] ny;
  always_comb begin
    slot_d = slot_q;
    hit = 1'b0;
    miss = 1'b0;
    ready = 1'b0;
    pix = 1'b0;
    found = 1'b0;
    best = '0;
    best_y = '0;
    free_idx = '0;
    ny = '0;
    xin = draw_x >= 10'(X0) && {1'b0, draw_x} < 11'(X0 + NOTE_SIZE);
    // strict > keeps the lowest slot on equal y
    for (int i = 0; i < NOTES; i++)
      if (slot_q[i].active && {1'b0, slot_q[i].y} >= WIN_LO && {1'b0, slot_q[i].y} <= WIN_HI &&
          (!found || slot_q[i].y > best_y)) begin
        found = 1'b1;
        best = IW'(i);
        best_y = slot_q[i].y;
      end
    for (int i = 0; i < NOTES; i++) begin
      ny = {1'b0, slot_q[i].y} + 11'(SPEED);
      if (press && found && best == IW'(i)) begin
        slot_d[i].active = 1'b0;
        hit = 1'b1;
      end else if (tick && slot_q[i].active) begin
        if (ny > WIN_HI) begin
          slot_d[i].active = 1'b0;
          miss = 1'b1;
        end else slot_d[i].y = ny[9:0];
      end
      if (!slot_q[i].active && !ready) begin
        ready = 1'b1;
        free_idx = IW'(i);
      end
      if (slot_q[i].active && xin && {1'b0, draw_y} >= {1'b0, slot_q[i].y} &&
          {1'b0, draw_y} < {1'b0, slot_q[i].y} + 11'(NOTE_SIZE))
        pix = 1'b1;
    end
    if (spawn && ready) slot_d[free_idx] = '{active: 1'b1, y: '0};
  end
  always_ff @(posedge clk)
    if (!rst_n) slot_q <= '0;
    else slot_q <= slot_d;
endmodule

// File: rtl/note_lane_engine.sv
// note_lane_engine: N-lane falling-note engine with hit judging, score, streak and pixel flags
// STREAK_MULT_EN: when defined, hits score 1/2/4 depending on the current streak
module note_lane_engine
  import note_pkg::*;
#(
  parameter int NUM_LANES      = 5,
  parameter int NOTES_PER_LANE = 4,
  parameter int SPEED          = 2,
  parameter int HIT_Y          = 420,
  parameter int HIT_WIN        = 12,
  parameter int LANE_X0        = 160,
  parameter int LANE_PITCH     = 64,
  parameter int NOTE_SIZE      = 16
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         frame_clk,
  input  logic                         spawn_valid,
  input  logic [$clog2(NUM_LANES)-1:0] spawn_lane,
  output logic                         spawn_ready,
  input  logic [NUM_LANES-1:0]         key_press,
  input  logic [9:0]                   DrawX,
  input  logic [9:0]                   DrawY,
  output logic [NUM_LANES-1:0]         is_note,
  output logic [15:0]                  score,
  output logic [7:0]                   streak,
  output logic                         hit_pulse,
  output logic                         miss_pulse
);
  localparam int LW = $clog2(NUM_LANES);
  localparam int HW = $clog2(NUM_LANES + 1);
  logic [NUM_LANES-1:0] key_q, press_q, press_d, ready, spawn_l, hit_l, miss_l;
  logic frame_q, tick_q, tick_d, hit_q, hit_d, miss_q, miss_d;
  logic [15:0] score_q, score_d;
  logic [7:0] streak_q, streak_d;
  logic [HW-1:0] nhits;
  logic [16:0] sum;
  logic [8:0] ssum;
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    note_lane #(
      .NOTES(NOTES_PER_LANE), .SPEED(SPEED), .HIT_Y(HIT_Y), .HIT_WIN(HIT_WIN),
      .X0(LANE_X0 + l * LANE_PITCH), .NOTE_SIZE(NOTE_SIZE)
    ) u_lane (
      .clk(Clk), .rst_n(Reset_n), .tick(tick_q), .spawn(spawn_l[l]), .press(press_q[l]),
      .draw_x(DrawX), .draw_y(DrawY), .ready(ready[l]), .hit(hit_l[l]), .miss(miss_l[l]),
      .pix(is_note[l])
    );
    assign spawn_l[l] = spawn_valid && spawn_lane == LW'(l) && ready[l];
  end
  always_comb begin
    spawn_ready = int'(spawn_lane) < NUM_LANES ? ready[spawn_lane] : 1'b0;
    tick_d = frame_clk & ~frame_q;
    press_d = key_press & ~key_q;
    hit_d = |hit_l;
    miss_d = |miss_l;
    nhits = '0;
    for (int i = 0; i < NUM_LANES; i++) nhits = nhits + HW'(hit_l[i]);
`ifdef STREAK_MULT_EN
    sum = {1'b0, score_q} + (17'(nhits) << (streak_q < 8'd8 ? 2'd0 : streak_q < 8'd16 ? 2'd1 : 2'd2));
`else
    sum = {1'b0, score_q} + 17'(nhits);
`endif
    score_d = sum[16] ? 16'hFFFF : sum[15:0];
    ssum = {1'b0, streak_q} + 9'(nhits);
    streak_d = miss_d ? 8'd0 : ssum > 9'(MAX_STREAK) ? 8'(MAX_STREAK) : ssum[7:0];
  end
  always_ff @(posedge Clk)
    if (!Reset_n) begin
      frame_q <= 1'b0;
      tick_q <= 1'b0;
      key_q <= '0;
      press_q <= '0;
      score_q <= '0;
      streak_q <= '0;
      hit_q <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      frame_q <= frame_clk;
      tick_q <= tick_d;
      key_q <= key_press;
      press_q <= press_d;
      score_q <= score_d;
      streak_q <= streak_d;
      hit_q <= hit_d;
      miss_q <= miss_d;
    end
  assign score = score_q;
  assign streak = streak_q;
  assign hit_pulse = hit_q;
  assign miss_pulse = miss_q;
endmodule

// File: tb/tb_note_lane_engine.sv
// tb_note_lane_engine: scoreboard bench; pulses are popped against queued expected events
module tb_note_lane_engine;
  logic Clk = 0, Reset_n = 0, frame_clk = 0, spawn_valid = 0;
  logic [2:0] spawn_lane = 0;
  logic spawn_ready;
  logic [4:0] key_press = 0, is_note;
  logic [9:0] DrawX = 0, DrawY = 0;
  logic [15:0] score;
  logic [7:0] streak;
  logic hit_pulse, miss_pulse;
  typedef struct packed {
    logic hit;
    logic miss;
    logic [15:0] score;
    logic [7:0] streak;
  } ev_t;
  ev_t exp_q[$];
  int total = 0, bad = 0;

  always #10 Clk = ~Clk;

  note_lane_engine dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .spawn_valid(spawn_valid),
    .spawn_lane(spawn_lane), .spawn_ready(spawn_ready), .key_press(key_press),
    .DrawX(DrawX), .DrawY(DrawY), .is_note(is_note), .score(score), .streak(streak),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge Clk)
    if (hit_pulse || miss_pulse) begin
      if (exp_q.size() == 0) check("unexpected pulse", {hit_pulse, miss_pulse}, 0);
      else begin
        ev_t e;
        e = exp_q.pop_front();
        check("hit_pulse", hit_pulse, e.hit);
        check("miss_pulse", miss_pulse, e.miss);
        check("score", score, e.score);
        check("streak", streak, e.streak);
      end
    end

  task automatic push_ev(input logic h, input logic m, input int s, input int k);
    exp_q.push_back('{h, m, 16'(s), 8'(k)});
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge Clk);
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      frame_clk = 1;
      cyc();
      frame_clk = 0;
      cyc();
    end
  endtask
  task automatic spawn(input int l);
    spawn_lane = 3'(l);
    spawn_valid = 1;
    cyc();
    spawn_valid = 0;
  endtask
  task automatic press(input logic [4:0] m);
    key_press = m;
    cyc();
    key_press = 0;
    cyc(3);
  endtask
  task automatic pix(input int x, input int y, input int exp, input string name);
    DrawX = 10'(x);
    DrawY = 10'(y);
    #1 check(name, is_note, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    cyc(3);
    check("rst score", score, 0);
    check("rst streak", streak, 0);
    check("rst pulses", {hit_pulse, miss_pulse}, 0);
    pix(288, 0, 0, "rst pix");
    #1 check("rst ready", spawn_ready, 1);
    Reset_n = 1;
    cyc();
    // single note falls to the target line and is hit
    spawn(2);
    pix(288, 0, 5'b00100, "spawn pix");
    tick(210);
    pix(288, 420, 5'b00100, "note top row");
    pix(288, 435, 5'b00100, "note bottom row");
    pix(288, 436, 0, "below note");
    pix(304, 420, 0, "right of note");
    pix(287, 420, 0, "left of note");
    push_ev(1, 0, 1, 1);
    press(5'b00100);
    // four simultaneous hits, then a missed note
    spawn(0); spawn(1); spawn(3); spawn(4);
    tick(210);
    push_ev(1, 0, 5, 5);
    press(5'b11011);
    spawn(0);
    tick(216);
    check("streak before miss", streak, 5);
    push_ev(0, 1, 5, 0);
    tick(1);
    cyc();
    check("score after miss", score, 5);
    // lane 1 full
    repeat (4) spawn(1);
    spawn_lane = 1;
    #1 check("full lane ready", spawn_ready, 0);
    spawn_lane = 3;
    #1 check("other lane ready", spawn_ready, 1);
    cyc();
    spawn_lane = 1;
    spawn_valid = 1;
    cyc();
    spawn_valid = 0;
    // two lane-3 notes at 424 and 414
    spawn(3);
    tick(5);
    spawn(3);
    tick(207);
    pix(352, 414, 5'b01000, "lower note present");
    pix(224, 424, 5'b00010, "lane1 notes at 424");
    push_ev(1, 0, 6, 1);
    press(5'b01000);
    pix(352, 414, 5'b01000, "y414 note kept");
    pix(352, 435, 0, "y424 note freed");
    push_ev(1, 0, 7, 2);
    press(5'b00010);
    // ghost press
    press(5'b10000);
    check("ghost score", score, 7);
    check("ghost streak", streak, 2);
    tick(4);
    push_ev(0, 1, 7, 0);
    tick(1);
    push_ev(0, 1, 7, 0);
    tick(5);
    pix(224, 434, 0, "lane1 cleared");
    pix(352, 434, 0, "lane3 cleared");
`ifdef STREAK_MULT_EN
    for (int l = 0; l < 4; l++) repeat (4) spawn(l);
    tick(210);
    push_ev(1, 0, 11, 4);
    press(5'b01111);
    push_ev(1, 0, 15, 8);
    press(5'b01111);
    push_ev(1, 0, 23, 12);
    press(5'b01111);
    push_ev(1, 0, 31, 16);
    press(5'b01111);
    spawn(4);
    tick(210);
    push_ev(1, 0, 35, 17);
    press(5'b10000);
`endif
    // reset mid-game
    spawn(0);
    tick(3);
    pix(160, 6, 5'b00001, "pre-reset pix");
    Reset_n = 0;
    cyc();
    check("midrst score", score, 0);
    check("midrst streak", streak, 0);
    check("midrst pulses", {hit_pulse, miss_pulse}, 0);
    pix(160, 6, 0, "midrst pix");
    Reset_n = 1;
    cyc();
    tick(1);
    pix(160, 8, 0, "post-reset pix");
    spawn_lane = 0;
    #1 check("post-reset ready", spawn_ready, 1);
    cyc(5);
    check("scoreboard drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
